// File: rtl/gvt_pkg.sv
// Shared definitions for the serial GVT sequencer: FSM encoding, default widths
// and the core-index width helper.
package gvt_pkg;

    localparam int DEF_TIME_WID = 16;
    localparam int DEF_NUM_CORE = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } gvt_state_e;

    // Index width for walking the core snapshot; never narrower than one bit.
    function automatic int idx_wid(input int num_core);
        return (num_core > 1) ? $clog2(num_core) : 1;
    endfunction

endpackage

// File: rtl/gvt_sequencer_if.sv
// Signal bundle between the PDES core array / event queue and the GVT sequencer.
interface gvt_sequencer_if #(
    parameter int NUM_CORE = gvt_pkg::DEF_NUM_CORE,
    parameter int TIME_WID = gvt_pkg::DEF_TIME_WID
);
    import gvt_pkg::*;

    // No valid/ready pair here: gvt_req is a fire-and-forget pulse that is
    // remembered while busy, and gvt_upd is a one-cycle strobe with no back-pressure.
    logic [TIME_WID*NUM_CORE-1:0] core_times;
    logic [NUM_CORE-1:0]          core_vld;
    logic [TIME_WID-1:0]          next_event;
    logic                         next_vld;
    logic                         auto_en;
    logic                         gvt_req;
    logic [TIME_WID-1:0]          gvt;
    logic                         gvt_upd;
    logic                         busy;
    logic                         sim_done;
    logic                         mono_err;
    gvt_state_e                   state;

    modport master (
        output core_times, core_vld, next_event, next_vld, auto_en, gvt_req,
        input  gvt, gvt_upd, busy, sim_done, mono_err, state
    );

    modport slave (
        input  core_times, core_vld, next_event, next_vld, auto_en, gvt_req,
        output gvt, gvt_upd, busy, sim_done, mono_err, state
    );

endinterface

// File: rtl/gvt_interval_timer.sv
// Down-counter that paces automatic GVT computations; saturates at zero and
// reloads to INTERVAL-1 whenever a computation is launched.
module gvt_interval_timer #(
    parameter int INTERVAL = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic reload,
    output logic expired
);

    localparam int              CNT_W      = $clog2(INTERVAL);
    localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(INTERVAL - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD_VAL;
        end else if (reload) begin
            cnt <= RELOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/gvt_sequencer.sv
// Serial GVT engine: snapshots core times and queue head, folds one core per cycle
// into a minimum, commits it. Optional monotonicity guard: GVT_MONO_CHECK_EN.
module gvt_sequencer
    import gvt_pkg::*;
#(
    parameter int NUM_CORE = DEF_NUM_CORE,
    parameter int TIME_WID = DEF_TIME_WID,
    parameter int INTERVAL = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    gvt_sequencer_if.slave  bus
);

    localparam int               IDX_W    = idx_wid(NUM_CORE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORE - 1);

    gvt_state_e          state, state_nxt;
    logic [TIME_WID-1:0] snap_time [NUM_CORE];
    logic [NUM_CORE-1:0] snap_vld;
    logic [TIME_WID-1:0] acc;
    logic                acc_vld;
    logic [IDX_W-1:0]    idx;
    logic [TIME_WID-1:0] gvt_q;
    logic                gvt_upd_q;
    logic                sim_done_q;
    logic                mono_err_q;
    logic                pending;
    logic                expired;
    logic                trigger;
    logic                take;
    logic [TIME_WID-1:0] cur_time;
    logic                cur_vld;
    logic                cur_wins;
    logic                commit_bad;
    logic                commit_upd;

    gvt_interval_timer #(.INTERVAL(INTERVAL)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (bus.auto_en),
        .reload  (take),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        trigger   = bus.gvt_req | pending | (bus.auto_en & expired);
        case (state)
            IDLE:    if (trigger) begin
                         take      = 1'b1;
                         state_nxt = SCAN;
                     end
            SCAN:    if (idx == LAST_IDX) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strict less-than: on a tie the earlier candidate stays (same value anyway).
    assign cur_time = snap_time[idx];
    assign cur_vld  = snap_vld[idx];
    assign cur_wins = cur_vld & (~acc_vld | (cur_time < acc));

`ifdef GVT_MONO_CHECK_EN
    assign commit_bad = acc_vld & (acc < gvt_q);
`else
    assign commit_bad = 1'b0;
`endif
    assign commit_upd = acc_vld & (acc != gvt_q) & ~commit_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CORE; i++) snap_time[i] <= '0;
            snap_vld   <= '0;
            acc        <= '0;
            acc_vld    <= 1'b0;
            idx        <= '0;
            gvt_q      <= '0;
            gvt_upd_q  <= 1'b0;
            sim_done_q <= 1'b0;
            pending    <= 1'b0;
        end else begin
            gvt_upd_q <= 1'b0;
            // Requests arriving mid-computation collapse into a single retry.
            if ((state != IDLE) && bus.gvt_req) pending <= 1'b1;
            else if (take)                      pending <= 1'b0;
            case (state)
                IDLE: if (take) begin
                    for (int i = 0; i < NUM_CORE; i++)
                        snap_time[i] <= bus.core_times[TIME_WID*i +: TIME_WID];
                    snap_vld <= bus.core_vld;
                    acc      <= bus.next_event;
                    acc_vld  <= bus.next_vld;
                    idx      <= '0;
                end
                SCAN: begin
                    if (cur_wins) acc <= cur_time;
                    acc_vld <= acc_vld | cur_vld;
                    idx     <= idx + IDX_W'(1);
                end
                COMMIT: begin
                    if (commit_upd) begin
                        gvt_q     <= acc;
                        gvt_upd_q <= 1'b1;
                    end
                    if (!acc_vld) sim_done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef GVT_MONO_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           mono_err_q <= 1'b0;
        else if ((state == COMMIT) && commit_bad) mono_err_q <= 1'b1;
    end
`else
    assign mono_err_q = 1'b0;
`endif

    assign bus.gvt      = gvt_q;
    assign bus.gvt_upd  = gvt_upd_q;
    assign bus.busy     = (state != IDLE);
    assign bus.sim_done = sim_done_q;
    assign bus.mono_err = mono_err_q;
    assign bus.state    = state;

endmodule
